// File: rtl/vme_irq_handler_if.sv
// Signal bundle between the VME interrupt handler, the VME backplane and the
// CPU interrupt/acknowledge logic.
interface vme_irq_handler_if;
    logic [6:0] vme_irq;
    logic [6:0] irq_mask;
    logic [2:0] vme_ipl;
    logic       iack_req;
    logic [2:0] iack_level;
    logic       vme_iack;
    logic [2:0] vme_iack_addr;
    logic       vme_ds;
    logic       vme_dtack;
    logic       vme_berr;
    logic [7:0] vme_vector;
    logic [7:0] iack_vector;
    logic       iack_done;
    logic       iack_error;

    modport master (
        input  vme_irq, irq_mask, iack_req, iack_level, vme_dtack, vme_berr, vme_vector,
        output vme_ipl, vme_iack, vme_iack_addr, vme_ds, iack_vector, iack_done, iack_error
    );

    modport slave (
        output vme_irq, irq_mask, iack_req, iack_level, vme_dtack, vme_berr, vme_vector,
        input  vme_ipl, vme_iack, vme_iack_addr, vme_ds, iack_vector, iack_done, iack_error
    );
endinterface

// File: rtl/vme_irq_handler.sv
// VME interrupt handler: synchronizes/masks IRQ1*..IRQ7*, presents the encoded
// level to the CPU and runs the VME interrupt-acknowledge cycle.
module vme_irq_handler #(
    parameter logic [7:0] TIMEOUT_CYCLES  = 8'd255,
    parameter logic [7:0] SPURIOUS_VECTOR = 8'h18
) (
    input  logic               clock,
    input  logic               reset,
    vme_irq_handler_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        STROBE  = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4,
        RELEASE = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] irq_meta_q, irq_sync_q;
    logic       req_meta_q, req_sync_q;
    logic       dtack_meta_q, dtack_sync_q;
    logic       berr_meta_q, berr_sync_q;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] ipl_q;
    logic [2:0] addr_q, addr_d;
    logic       iack_q, iack_d;
    logic       ds_q, ds_d;
    logic [7:0] vec_q, vec_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [6:0] pending_s;

    function automatic logic [2:0] encode_level(input logic [6:0] p);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (p[i]) begin
                lvl = 3'(i + 1);
            end else begin
                lvl = lvl;
            end
        end
        return lvl;
    endfunction

    assign pending_s = ~irq_sync_q & bus.irq_mask;

    // Two-flop synchronizers for every asynchronous VME/CPU input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            irq_meta_q   <= 7'h7F;
            irq_sync_q   <= 7'h7F;
            req_meta_q   <= 1'b1;
            req_sync_q   <= 1'b1;
            dtack_meta_q <= 1'b1;
            dtack_sync_q <= 1'b1;
            berr_meta_q  <= 1'b1;
            berr_sync_q  <= 1'b1;
        end else begin
            irq_meta_q   <= bus.vme_irq;
            irq_sync_q   <= irq_meta_q;
            req_meta_q   <= bus.iack_req;
            req_sync_q   <= req_meta_q;
            dtack_meta_q <= bus.vme_dtack;
            dtack_sync_q <= dtack_meta_q;
            berr_meta_q  <= bus.vme_berr;
            berr_sync_q  <= berr_meta_q;
        end
    end

    // State and registered outputs; the IPL only follows the IRQs while idle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ipl_q   <= 3'b111;
            addr_q  <= 3'b000;
            iack_q  <= 1'b1;
            ds_q    <= 1'b1;
            vec_q   <= 8'h00;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ipl_q   <= (state_q == IDLE) ? ~encode_level(pending_s) : ipl_q;
            addr_q  <= addr_d;
            iack_q  <= iack_d;
            ds_q    <= ds_d;
            vec_q   <= vec_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state; outputs are computed for the state being entered so they
    // change on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        iack_d  = iack_q;
        ds_d    = ds_q;
        vec_d   = vec_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (!req_sync_q) begin
                    state_d = START;
                    addr_d  = bus.iack_level;
                    cnt_d   = 8'd0;
                    iack_d  = 1'b0;
                    ds_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (req_sync_q) begin
                    state_d = RELEASE;
                    iack_d  = 1'b1;
                    ds_d    = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (addr_q == 3'd0) begin
                    // Level 0 is not a valid IACK level: fail without strobing DS0*.
                    state_d = DONE;
                    vec_d   = SPURIOUS_VECTOR;
                    err_d   = 1'b0;
                end else begin
                    state_d = STROBE;
                    ds_d    = 1'b0;
                end
            end
            STROBE: begin
                if (req_sync_q) begin
                    state_d = RELEASE;
                    iack_d  = 1'b1;
                    ds_d    = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (req_sync_q) begin
                    state_d = RELEASE;
                    iack_d  = 1'b1;
                    ds_d    = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (!berr_sync_q || (dtack_sync_q && (cnt_q == TIMEOUT_CYCLES))) begin
                    state_d = DONE;
                    vec_d   = SPURIOUS_VECTOR;
                    err_d   = 1'b0;
                end else if (!dtack_sync_q) begin
                    state_d = DONE;
                    vec_d   = bus.vme_vector;
                    done_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (req_sync_q) begin
                    state_d = RELEASE;
                    iack_d  = 1'b1;
                    ds_d    = 1'b1;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            RELEASE: begin
                if (dtack_sync_q && berr_sync_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
                iack_d  = 1'b1;
                ds_d    = 1'b1;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
        endcase
    end

    assign bus.vme_ipl       = ipl_q;
    assign bus.vme_iack      = iack_q;
    assign bus.vme_iack_addr = addr_q;
    assign bus.vme_ds        = ds_q;
    assign bus.iack_vector   = vec_q;
    assign bus.iack_done     = done_q;
    assign bus.iack_error    = err_q;

endmodule
